// File: rtl/orb_bank_ctrl.sv
// Ping-pong bank controller for the two orbital frame RAMs: the writer fills one
// bank while the reader drains the other. Optional statistics under ORB_BANK_STAT_EN.
module orb_bank_ctrl #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 12,
   parameter logic [DATA_W-1:0] FILL_WORD = 12'h000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_frame_done,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_frame_sw,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] ram_wraddr,
   output logic [DATA_W-1:0] ram_data,
   output logic [1:0]        ram_wren,
   output logic [ADDR_W-1:0] ram_rdaddr,
   output logic [1:0]        ram_rden,
   input  logic [DATA_W-1:0] ram_q0,
   input  logic [DATA_W-1:0] ram_q1,
   output logic              wr_bank,
   output logic              overrun,
   output logic              underrun
`ifdef ORB_BANK_STAT_EN
   ,
   output logic [15:0]       ovr_cnt,
   output logic [15:0]       udr_cnt
`endif
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t state, state_nx;
   logic   wr_full;
   logic   frame_ready;
   logic   swap_ok;
   logic   wr_accept;
   logic   wr_drop;
   logic   swap_refused;

   // Read pipeline: bank and fill flag travel with the request
   logic   rd_pend1, rd_bank1, rd_fill1;
   logic   rd_pend2, rd_bank2, rd_fill2;

   // A frame_done arriving with the swap counts as already complete
   always_comb begin
      frame_ready  = wr_full | wr_frame_done;
      swap_ok      = rd_frame_sw & frame_ready;
      swap_refused = rd_frame_sw & ~frame_ready;
      wr_accept    = wr_en & ~wr_full;
      wr_drop      = wr_en & wr_full;
      state_nx     = state;
      if (state == ST_EMPTY && swap_ok)
         state_nx = ST_RUN;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= ST_EMPTY;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_bank <= 1'b0;
         wr_full <= 1'b0;
      end else if (swap_ok) begin
         wr_bank <= ~wr_bank;
         wr_full <= 1'b0;
      end else if (wr_frame_done) begin
         wr_full <= 1'b1;
      end
   end

   // Writes use the pre-swap bank even when a swap lands on the same edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_wren   <= 2'b00;
         ram_wraddr <= '0;
         ram_data   <= '0;
         overrun    <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         ram_wren <= 2'b00;
         if (wr_accept) begin
            ram_wren[wr_bank] <= 1'b1;
            ram_wraddr        <= wr_addr;
            ram_data          <= wr_data;
         end
         overrun  <= wr_drop;
         underrun <= swap_refused;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_rden   <= 2'b00;
         ram_rdaddr <= '0;
         rd_pend1   <= 1'b0;
         rd_bank1   <= 1'b0;
         rd_fill1   <= 1'b0;
         rd_pend2   <= 1'b0;
         rd_bank2   <= 1'b0;
         rd_fill2   <= 1'b0;
      end else begin
         ram_rden <= 2'b00;
         if (rd_en) begin
            ram_rdaddr <= rd_addr;
            if (state == ST_RUN)
               ram_rden[~wr_bank] <= 1'b1;
         end
         rd_pend1 <= rd_en;
         rd_bank1 <= ~wr_bank;
         rd_fill1 <= (state == ST_EMPTY);
         rd_pend2 <= rd_pend1;
         rd_bank2 <= rd_bank1;
         rd_fill2 <= rd_fill1;
      end
   end

   // Output is forced to zero when idle so reset leaves every output at 0
   always_comb begin
      rd_valid = rd_pend2;
      rd_data  = '0;
      if (rd_pend2) begin
         if (rd_fill2)
            rd_data = FILL_WORD;
         else if (rd_bank2)
            rd_data = ram_q1;
         else
            rd_data = ram_q0;
      end
   end

`ifdef ORB_BANK_STAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovr_cnt <= 16'h0000;
         udr_cnt <= 16'h0000;
      end else begin
         if (wr_drop && ovr_cnt != 16'hFFFF)
            ovr_cnt <= ovr_cnt + 16'h0001;
         if (swap_refused && udr_cnt != 16'hFFFF)
            udr_cnt <= udr_cnt + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_orb_bank_ctrl.sv
// Directed self-checking bench for orb_bank_ctrl with a behavioural pair of
// 1-cycle registered RAMs attached to the shared address/data buses.
module tb_orb_bank_ctrl;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_frame_done;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_frame_sw;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [ADDR_W-1:0] ram_wraddr;
   logic [DATA_W-1:0] ram_data;
   logic [1:0]        ram_wren;
   logic [ADDR_W-1:0] ram_rdaddr;
   logic [1:0]        ram_rden;
   logic [DATA_W-1:0] ram_q0;
   logic [DATA_W-1:0] ram_q1;
   logic              wr_bank;
   logic              overrun;
   logic              underrun;
`ifdef ORB_BANK_STAT_EN
   logic [15:0]       ovr_cnt;
   logic [15:0]       udr_cnt;
`endif

   int tests = 0;
   int fails = 0;

   orb_bank_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FILL_WORD(12'h000)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_frame_done(wr_frame_done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_frame_sw(rd_frame_sw),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .ram_wraddr(ram_wraddr), .ram_data(ram_data), .ram_wren(ram_wren),
      .ram_rdaddr(ram_rdaddr), .ram_rden(ram_rden),
      .ram_q0(ram_q0), .ram_q1(ram_q1),
      .wr_bank(wr_bank), .overrun(overrun), .underrun(underrun)
`ifdef ORB_BANK_STAT_EN
      , .ovr_cnt(ovr_cnt), .udr_cnt(udr_cnt)
`endif
   );

   always #6 clk = ~clk;

   // Two RAM banks with registered read data
   logic [DATA_W-1:0] mem0 [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] mem1 [0:(1<<ADDR_W)-1];

   always @(posedge clk) begin
      if (ram_wren[0]) mem0[ram_wraddr] <= ram_data;
      if (ram_wren[1]) mem1[ram_wraddr] <= ram_data;
      if (ram_rden[0]) ram_q0 <= mem0[ram_rdaddr];
      if (ram_rden[1]) ram_q1 <= mem1[ram_rdaddr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_frame_done = 1'b0;
      rd_en = 1'b0; rd_addr = '0; rd_frame_sw = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             output logic [1:0] wren_seen);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wren_seen = ram_wren;
      wr_en = 1'b0;
   endtask

   task automatic pulse_done();
      wr_frame_done = 1'b1;
      tick();
      wr_frame_done = 1'b0;
   endtask

   task automatic pulse_swap(output logic udr_seen);
      rd_frame_sw = 1'b1;
      tick();
      udr_seen = underrun;
      rd_frame_sw = 1'b0;
   endtask

   // Issues one read and returns what appears two clocks later
   task automatic do_read(input logic [ADDR_W-1:0] a, output logic [1:0] rden_seen,
                          output logic v1, output logic v2, output logic [DATA_W-1:0] d);
      rd_en = 1'b1; rd_addr = a;
      tick();
      rden_seen = ram_rden;
      v1 = rd_valid;
      rd_en = 1'b0;
      tick();
      v2 = rd_valid;
      d  = rd_data;
   endtask

   task automatic test_reset();
      logic [1:0] rden; logic v1, v2; logic [DATA_W-1:0] d;
      idle_inputs();
      rst = 1'b0;
      #3;
      tests++;
      if ({rd_valid, ram_wren, ram_rden, wr_bank, overrun, underrun} !== 7'b0) begin
         fails++;
         $display("[TB] FAIL reset_ctrl: got %b, expected 0", {rd_valid, ram_wren, ram_rden, wr_bank, overrun, underrun});
      end
      tick();
      rst = 1'b1;
      tick();
      do_read(11'd5, rden, v1, v2, d);
      tests++;
      if (rden !== 2'b00) begin fails++; $display("[TB] FAIL empty_rden: got %b, expected 00", rden); end
      tests++;
      if (v1 !== 1'b0 || v2 !== 1'b1) begin fails++; $display("[TB] FAIL empty_latency: got v1=%b v2=%b, expected 0 1", v1, v2); end
      tests++;
      if (d !== 12'h000) begin fails++; $display("[TB] FAIL empty_fill: got %h, expected 000", d); end
   endtask

   task automatic test_fill_swap();
      logic [1:0] wren, rden; logic v1, v2, u; logic [DATA_W-1:0] d;
      for (int i = 0; i < 4; i++) begin
         write_word(ADDR_W'(i), DATA_W'(12'hA00 + i), wren);
         tests++;
         if (wren !== 2'b01 || ram_wraddr !== ADDR_W'(i) || ram_data !== DATA_W'(12'hA00 + i)) begin
            fails++;
            $display("[TB] FAIL fill_bank0_%0d: got wren=%b a=%h d=%h, expected 01 %h %h", i, wren, ram_wraddr, ram_data, i, 12'hA00 + i);
         end
      end
      pulse_done();
      pulse_swap(u);
      tests++;
      if (wr_bank !== 1'b1 || u !== 1'b0) begin fails++; $display("[TB] FAIL swap1: got bank=%b udr=%b, expected 1 0", wr_bank, u); end
      do_read(11'd2, rden, v1, v2, d);
      tests++;
      if (rden !== 2'b01 || ram_rdaddr !== 11'd2) begin fails++; $display("[TB] FAIL read_bank0_req: got rden=%b a=%h, expected 01 002", rden, ram_rdaddr); end
      tests++;
      if (v1 !== 1'b0 || v2 !== 1'b1 || d !== 12'hA02) begin fails++; $display("[TB] FAIL read_bank0: got v=%b%b d=%h, expected 01 a02", v1, v2, d); end
   endtask

   task automatic test_underrun();
      logic [1:0] rden; logic v1, v2, u; logic [DATA_W-1:0] d;
      pulse_swap(u);
      tests++;
      if (u !== 1'b1 || wr_bank !== 1'b1) begin fails++; $display("[TB] FAIL underrun_pulse: got udr=%b bank=%b, expected 1 1", u, wr_bank); end
      tick();
      tests++;
      if (underrun !== 1'b0) begin fails++; $display("[TB] FAIL underrun_width: got %b, expected 0", underrun); end
      do_read(11'd2, rden, v1, v2, d);
      tests++;
      if (v2 !== 1'b1 || d !== 12'hA02) begin fails++; $display("[TB] FAIL stale_reread: got v=%b d=%h, expected 1 a02", v2, d); end
   endtask

   task automatic test_overrun();
      logic [1:0] wren;
      for (int i = 0; i < 4; i++) begin
         write_word(ADDR_W'(i), DATA_W'(12'hB00 + i), wren);
         tests++;
         if (wren !== 2'b10) begin fails++; $display("[TB] FAIL fill_bank1_%0d: got wren=%b, expected 10", i, wren); end
      end
      pulse_done();
      write_word(11'd7, 12'h7FF, wren);
      tests++;
      if (overrun !== 1'b1 || wren !== 2'b00) begin fails++; $display("[TB] FAIL overrun: got ovr=%b wren=%b, expected 1 00", overrun, wren); end
      tick();
      tests++;
      if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL overrun_width: got %b, expected 0", overrun); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] wren, rden; logic v1, v2, u; logic [DATA_W-1:0] d;
      pulse_swap(u);
      tests++;
      if (u !== 1'b0 || wr_bank !== 1'b0) begin fails++; $display("[TB] FAIL swap2: got udr=%b bank=%b, expected 0 0", u, wr_bank); end
      write_word(11'd2, 12'hC02, wren);
      // Read issued, then done + swap + write all on the following edge
      rd_en = 1'b1; rd_addr = 11'd2;
      tick();
      rd_en = 1'b0;
      wr_frame_done = 1'b1; rd_frame_sw = 1'b1;
      wr_en = 1'b1; wr_addr = 11'd9; wr_data = 12'hD09;
      tick();
      wr_frame_done = 1'b0; rd_frame_sw = 1'b0; wr_en = 1'b0;
      tests++;
      if (rd_valid !== 1'b1 || rd_data !== 12'hB02) begin fails++; $display("[TB] FAIL inflight_read: got v=%b d=%h, expected 1 b02", rd_valid, rd_data); end
      tests++;
      if (underrun !== 1'b0 || wr_bank !== 1'b1) begin fails++; $display("[TB] FAIL done_swap: got udr=%b bank=%b, expected 0 1", underrun, wr_bank); end
      tests++;
      if (ram_wren !== 2'b01 || ram_wraddr !== 11'd9) begin fails++; $display("[TB] FAIL write_preswap: got wren=%b a=%h, expected 01 009", ram_wren, ram_wraddr); end
      do_read(11'd2, rden, v1, v2, d);
      tests++;
      if (rden !== 2'b01 || d !== 12'hC02) begin fails++; $display("[TB] FAIL new_bank_read: got rden=%b d=%h, expected 01 c02", rden, d); end
      do_read(11'd9, rden, v1, v2, d);
      tests++;
      if (d !== 12'hD09) begin fails++; $display("[TB] FAIL preswap_word: got %h, expected d09", d); end
   endtask

   task automatic test_stats_and_reset();
      logic [1:0] wren; logic u;
      do_reset();
      for (int i = 0; i < 3; i++) pulse_swap(u);
      pulse_done();
      write_word(11'd1, 12'h111, wren);
`ifdef ORB_BANK_STAT_EN
      tests++;
      if (udr_cnt !== 16'd3 || ovr_cnt !== 16'd1) begin fails++; $display("[TB] FAIL stat_counts: got udr=%0d ovr=%0d, expected 3 1", udr_cnt, ovr_cnt); end
`endif
      pulse_swap(u);
      rd_en = 1'b1; rd_addr = 11'd3;
      wr_en = 1'b1; wr_addr = 11'd4; wr_data = 12'h444;
      tick();
      tests++;
      if (wr_bank !== 1'b1 || ram_wren !== 2'b10 || ram_rden !== 2'b01) begin
         fails++;
         $display("[TB] FAIL pre_reset_state: got bank=%b wren=%b rden=%b, expected 1 10 01", wr_bank, ram_wren, ram_rden);
      end
      #2;
      rst = 1'b0;
      #1;
      tests++;
      if ({rd_valid, rd_data, ram_wren, ram_rden, wr_bank, overrun, underrun} !== 19'b0 ||
          ram_wraddr !== '0 || ram_data !== '0 || ram_rdaddr !== '0) begin
         fails++;
         $display("[TB] FAIL midwrite_reset: got v=%b d=%h wren=%b rden=%b bank=%b wa=%h wd=%h ra=%h, expected all 0",
                  rd_valid, rd_data, ram_wren, ram_rden, wr_bank, ram_wraddr, ram_data, ram_rdaddr);
      end
`ifdef ORB_BANK_STAT_EN
      tests++;
      if (udr_cnt !== 16'd0 || ovr_cnt !== 16'd0) begin fails++; $display("[TB] FAIL stat_reset: got udr=%0d ovr=%0d, expected 0 0", udr_cnt, ovr_cnt); end
`endif
      idle_inputs();
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      test_reset();
      test_fill_swap();
      test_underrun();
      test_overrun();
      test_back_to_back();
      test_stats_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
